// File: rtl/mole_sched_if.sv
// mole_sched_if: record/play control and mole-request bundle between game logic and the scheduler.
interface mole_sched_if #(
    parameter int AW = 23,
    parameter int CW = 5
);
    logic          record_en;
    logic          play_en;
    logic          stomp;
    logic [AW-1:0] music_address;
    logic          request_mole;
    logic [CW-1:0] mole_count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          done;
    logic [1:0]    sched_state;
    modport master (
        output record_en, play_en, stomp, music_address,
        input  request_mole, mole_count, full, empty, overflow, done, sched_state
    );
    modport slave (
        input  record_en, play_en, stomp, music_address,
        output request_mole, mole_count, full, empty, overflow, done, sched_state
    );
endinterface

// File: rtl/mole_scheduler.sv
// mole_scheduler: records stomp times as music addresses and replays them as mole requests.
module mole_scheduler #(
    parameter int            DEPTH   = 16,
    parameter int            AW      = 23,
    parameter logic [AW-1:0] MIN_GAP = 'h1000
) (
    input logic         clk,
    input logic         reset,
    mole_sched_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE = 2'd0, RECORD = 2'd1, PLAY = 2'd2, DONE = 2'd3} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] last_q, last_d;
    logic          req_q, req_d;
    logic          ovf_q, ovf_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          done_q, done_d;
    logic          wr_en;
    logic [AW-1:0] mem_q [DEPTH];
    logic [AW:0]   next_min;
    logic          addr_ok;
    // A carry out of last+MIN_GAP makes next_min exceed any AW-bit address
    assign next_min = {1'b0, last_q} + {1'b0, MIN_GAP};
    assign addr_ok  = {1'b0, bus.music_address} >= next_min;
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        req_d    = 1'b0;
        ovf_d    = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.record_en) begin
                    state_d = RECORD;
                    count_d = '0;
                end else if (bus.play_en) begin
                    state_d  = PLAY;
                    rd_ptr_d = '0;
                end
            end
            RECORD: begin
                if (!bus.record_en) begin
                    state_d = IDLE;
                end else if (bus.stomp) begin
                    if (full_q) begin
                        ovf_d = 1'b1;
                    end else if (empty_q || addr_ok) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                        last_d  = bus.music_address;
                    end
                end
            end
            PLAY: begin
                if (!bus.play_en) begin
                    state_d = IDLE;
                end else if (empty_q) begin
                    state_d = DONE;
                end else if (bus.music_address >= mem_q[rd_ptr_q[PW-1:0]]) begin
                    req_d    = 1'b1;
                    rd_ptr_d = rd_ptr_q + CW'(1);
                    state_d  = (rd_ptr_d == count_q) ? DONE : PLAY;
                end
            end
            default: state_d = bus.play_en ? DONE : IDLE;
        endcase
        full_d  = count_d == CW'(DEPTH);
        empty_d = count_d == '0;
        done_d  = state_d == DONE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
            req_q    <= 1'b0;
            ovf_q    <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
            req_q    <= req_d;
            ovf_q    <= ovf_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            done_q   <= done_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[count_q[PW-1:0]] <= bus.music_address;
    end
    assign bus.request_mole = req_q;
    assign bus.mole_count   = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.overflow     = ovf_q;
    assign bus.done         = done_q;
    assign bus.sched_state  = state_q;
endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: vector table plus directed sequences for record, replay and corner cases.
`timescale 1ns/1ps
module tb_mole_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    mole_sched_if #(.AW(23), .CW(5)) bus ();
    mole_scheduler #(.DEPTH(16), .AW(23), .MIN_GAP(23'h1000)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic        rec;
        logic        play;
        logic        stomp;
        logic [22:0] addr;
        int          st;
        int          cnt;
        int          full;
        int          empty;
        int          ovf;
        int          req;
        int          done;
    } vec_t;
    vec_t tbl [16];
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step(input logic rec, input logic play, input logic stomp, input logic [22:0] addr);
        bus.record_en     = rec;
        bus.play_en       = play;
        bus.stomp         = stomp;
        bus.music_address = addr;
        @(posedge clk);
        #1;
    endtask
    task automatic record3();
        step(1, 0, 0, 23'h0);
        step(1, 0, 1, 23'h8B00);
        step(1, 0, 1, 23'h14900);
        step(1, 0, 1, 23'h17B00);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int k;
        int pulses;
        logic [22:0] ents [3];
        ents[0] = 23'h8B00; ents[1] = 23'h14900; ents[2] = 23'h17B00;
        tbl[0]  = '{1, 0, 0, 23'h0,      1, 0, 0, 1, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 23'h8B00,   1, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 23'h8F00,   1, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 1, 23'h9B00,   1, 2, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 1, 23'h9000,   1, 2, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 1, 23'h20000,  0, 2, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 23'h0,      2, 2, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 23'h8B00,   2, 2, 0, 0, 0, 1, 0};
        tbl[8]  = '{0, 1, 0, 23'h9A00,   2, 2, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 23'h9B00,   3, 2, 0, 0, 0, 1, 1};
        tbl[10] = '{0, 1, 0, 23'h9B00,   3, 2, 0, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 0, 23'h0,      0, 2, 0, 0, 0, 0, 0};
        tbl[12] = '{1, 0, 0, 23'h0,      1, 0, 0, 1, 0, 0, 0};
        tbl[13] = '{1, 0, 1, 23'h7FF800, 1, 1, 0, 0, 0, 0, 0};
        tbl[14] = '{1, 0, 1, 23'h7FFFFF, 1, 1, 0, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 23'h0,      0, 1, 0, 0, 0, 0, 0};
        bus.record_en = 0; bus.play_en = 0; bus.stomp = 0; bus.music_address = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", bus.sched_state, 0);
        chk("rst_count", bus.mole_count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_req", bus.request_mole, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_done", bus.done, 0);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rec, tbl[i].play, tbl[i].stomp, tbl[i].addr);
            chk($sformatf("v%0d_state", i), bus.sched_state, tbl[i].st);
            chk($sformatf("v%0d_count", i), bus.mole_count, tbl[i].cnt);
            chk($sformatf("v%0d_full", i), bus.full, tbl[i].full);
            chk($sformatf("v%0d_empty", i), bus.empty, tbl[i].empty);
            chk($sformatf("v%0d_ovf", i), bus.overflow, tbl[i].ovf);
            chk($sformatf("v%0d_req", i), bus.request_mole, tbl[i].req);
            chk($sformatf("v%0d_done", i), bus.done, tbl[i].done);
        end
        step(1, 0, 0, 23'h0);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 1, 23'(i * 'h1000));
            chk("fill_count", bus.mole_count, i + 1);
            chk("fill_full", bus.full, (i == 15) ? 1 : 0);
            chk("fill_ovf", bus.overflow, 0);
        end
        step(1, 0, 1, 23'h10000);
        chk("ovf_pulse", bus.overflow, 1);
        chk("ovf_count", bus.mole_count, 16);
        step(1, 0, 0, 23'h10000);
        chk("ovf_clear", bus.overflow, 0);
        chk("ovf_full", bus.full, 1);
        step(0, 0, 0, 23'h0);
        record3();
        step(0, 0, 0, 23'h0);
        chk("ramp_count", bus.mole_count, 3);
        step(0, 1, 0, 23'h0);
        chk("ramp_enter", bus.sched_state, 2);
        k = 0;
        pulses = 0;
        for (int a = 0; a <= 'h20000; a += 'h100) begin
            logic exp_req;
            step(0, 1, 0, 23'(a));
            exp_req = (k < 3) && (23'(a) >= ents[k]);
            if (exp_req) k++;
            if (bus.request_mole) pulses++;
            chk($sformatf("ramp_req_%0h", a), bus.request_mole, exp_req);
        end
        chk("ramp_pulses", pulses, 3);
        chk("ramp_done", bus.done, 1);
        chk("ramp_state", bus.sched_state, 3);
        step(0, 0, 0, 23'h0);
        chk("done_exit", bus.done, 0);
        step(0, 1, 0, 23'h0);
        step(0, 1, 0, 23'h20000);
        chk("jump_req0", bus.request_mole, 1);
        step(0, 1, 0, 23'h20000);
        chk("jump_req1", bus.request_mole, 1);
        chk("jump_st1", bus.sched_state, 2);
        step(0, 1, 0, 23'h20000);
        chk("jump_req2", bus.request_mole, 1);
        chk("jump_st2", bus.sched_state, 3);
        step(0, 1, 0, 23'h20000);
        chk("jump_req3", bus.request_mole, 0);
        chk("jump_done", bus.done, 1);
        step(0, 0, 0, 23'h0);
        step(0, 1, 0, 23'h0);
        step(0, 1, 0, 23'h20000);
        chk("abort_req", bus.request_mole, 1);
        step(0, 0, 0, 23'h20000);
        chk("abort_state", bus.sched_state, 0);
        chk("abort_req_off", bus.request_mole, 0);
        step(0, 0, 0, 23'h20000);
        chk("abort_idle_req", bus.request_mole, 0);
        step(0, 1, 0, 23'h0);
        chk("replay_state", bus.sched_state, 2);
        step(0, 1, 0, 23'h8B00);
        chk("replay_first", bus.request_mole, 1);
        step(0, 1, 0, 23'h8B00);
        chk("replay_second", bus.request_mole, 0);
        chk("replay_count", bus.mole_count, 3);
        step(0, 0, 0, 23'h0);
        record3();
        chk("mid_count", bus.mole_count, 3);
        chk("mid_state", bus.sched_state, 1);
        reset = 1'b0;
        #1;
        chk("async_count", bus.mole_count, 0);
        chk("async_state", bus.sched_state, 0);
        step(1, 0, 1, 23'h30000);
        chk("mid_rst_count", bus.mole_count, 0);
        chk("mid_rst_empty", bus.empty, 1);
        chk("mid_rst_state", bus.sched_state, 0);
        chk("mid_rst_req", bus.request_mole, 0);
        chk("mid_rst_ovf", bus.overflow, 0);
        bus.record_en = 0; bus.stomp = 0;
        #1;
        reset = 1'b1;
        step(0, 1, 0, 23'h20000);
        chk("empty_play_st", bus.sched_state, 2);
        step(0, 1, 0, 23'h20000);
        chk("empty_play_done_st", bus.sched_state, 3);
        chk("empty_play_done", bus.done, 1);
        chk("empty_play_req", bus.request_mole, 0);
        step(0, 0, 0, 23'h0);
        chk("empty_play_exit", bus.sched_state, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
